// File: rtl/dpram_arbiter.sv
// Round-robin arbiter/sequencer for a simple dual-port RAM: two writers share port A,
// two readers share port B with tagged return. Optional counters: `define DPRAM_ARB_STATS_EN.
module dpram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w0_req,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  output logic                  w0_gnt,
  input  logic                  w1_req,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  output logic                  w1_gnt,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_gnt,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_rvalid,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_gnt,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_wena,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_renb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  logic                  wr_last_q, rd_last_q;
  logic                  wr_any, rd_any, wr_id, rd_id;
  logic [ADDR_WIDTH-1:0] wr_addr_d, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  logic [ADDR_WIDTH-1:0] ram_addra_q, ram_addrb_q;
  logic [DATA_WIDTH-1:0] ram_dina_q;
  logic                  ram_wena_q, ram_renb_q;
  logic [RD_LAT:0]       tag_v_q, tag_id_q;
  logic [DATA_WIDTH-1:0] r0_rdata_q, r1_rdata_q;
  logic                  r0_rvalid_q, r1_rvalid_q;

  // A client wins if it is the only requester or the other client was granted last.
  always_comb begin
    w0_gnt = !rst && w0_req && (!w1_req || wr_last_q);
    w1_gnt = !rst && w1_req && (!w0_req || !wr_last_q);
    r0_gnt = !rst && r0_req && (!r1_req || rd_last_q);
    r1_gnt = !rst && r1_req && (!r0_req || !rd_last_q);
    wr_any    = w0_gnt || w1_gnt;
    rd_any    = r0_gnt || r1_gnt;
    wr_id     = w1_gnt;
    rd_id     = r1_gnt;
    wr_addr_d = wr_id ? w1_addr : w0_addr;
    wr_data_d = wr_id ? w1_data : w0_data;
    rd_addr_d = rd_id ? r1_addr : r0_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last_q   <= 1'b1;
      rd_last_q   <= 1'b1;
      ram_addra_q <= '0;
      ram_dina_q  <= '0;
      ram_wena_q  <= 1'b0;
      ram_addrb_q <= '0;
      ram_renb_q  <= 1'b0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      ram_wena_q <= wr_any;
      ram_renb_q <= 1'b1;
      if (wr_any) begin
        wr_last_q   <= wr_id;
        ram_addra_q <= wr_addr_d;
        ram_dina_q  <= wr_data_d;
      end
      if (rd_any) begin
        rd_last_q   <= rd_id;
        ram_addrb_q <= rd_addr_d;
      end
      // Final tag stage lines up with ram_doutb for the read issued RD_LAT+1 cycles earlier.
      tag_v_q  <= {tag_v_q[RD_LAT-1:0], rd_any};
      tag_id_q <= {tag_id_q[RD_LAT-1:0], rd_id};
      r0_rvalid_q <= tag_v_q[RD_LAT] && !tag_id_q[RD_LAT];
      r1_rvalid_q <= tag_v_q[RD_LAT] &&  tag_id_q[RD_LAT];
      if (tag_v_q[RD_LAT] && !tag_id_q[RD_LAT]) r0_rdata_q <= ram_doutb;
      if (tag_v_q[RD_LAT] &&  tag_id_q[RD_LAT]) r1_rdata_q <= ram_doutb;
    end
  end

  assign ram_addra = ram_addra_q;
  assign ram_dina  = ram_dina_q;
  assign ram_wena  = ram_wena_q;
  assign ram_addrb = ram_addrb_q;
  assign ram_renb  = ram_renb_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;

`ifdef DPRAM_ARB_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q, stall_cnt_q;
  logic        stall;

  always_comb begin
    stall = (w0_req && !w0_gnt) || (w1_req && !w1_gnt) ||
            (r0_req && !r0_gnt) || (r1_req && !r1_gnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_q + 32'(wr_any);
      rd_cnt_q    <= rd_cnt_q + 32'(rd_any);
      stall_cnt_q <= stall_cnt_q + 32'(stall);
    end
  end

  assign stat_wr_cnt    = wr_cnt_q;
  assign stat_rd_cnt    = rd_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Scoreboard bench for dpram_arbiter: a RAM model, a spec-level reference of arbitration
// and memory contents, and a monitor that checks every read return against a queue.
module tb_dpram_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RD_LAT = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] wreq, rreq;
  logic [AW-1:0] waddr [2];
  logic [DW-1:0] wdata [2];
  logic [AW-1:0] raddr [2];
  logic w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;
  logic ram_wena, ram_renb;
`ifdef DPRAM_ARB_STATS_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
  int unsigned m_wr, m_rd, m_stall;
`endif

  always #5 clk = ~clk;

  dpram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .w0_req(wreq[0]), .w0_addr(waddr[0]), .w0_data(wdata[0]), .w0_gnt(w0_gnt),
    .w1_req(wreq[1]), .w1_addr(waddr[1]), .w1_data(wdata[1]), .w1_gnt(w1_gnt),
    .r0_req(rreq[0]), .r0_addr(raddr[0]), .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
    .r1_req(rreq[1]), .r1_addr(raddr[1]), .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wena(ram_wena),
    .ram_addrb(ram_addrb), .ram_renb(ram_renb), .ram_doutb(ram_doutb)
`ifdef DPRAM_ARB_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 9) ? DW'(32'h11) : DW'(i * 3);
  endfunction

  // RAM: write at the edge after ram_wena, read sampled when addrb is presented, RD_LAT deep.
  logic preload;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (ram_wena) begin
      mem[ram_addra] <= ram_dina;
    end
    if (ram_renb) begin
      pipe[0] <= mem[ram_addrb];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign ram_doutb = pipe[RD_LAT-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          id;
    logic [DW-1:0] data;
    int unsigned due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit wr_last, rd_last;
  bit [1:0] wgot, rgot;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [1:0] arb(input bit [1:0] req, input bit last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  task automatic reinit_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
  endtask

  // One cycle: called #1 after a posedge with inputs set; returns #1 after the next posedge.
  task automatic step(input bit do_rst);
    bit [1:0] ewg, erg;
    bit id;
    rst = do_rst;
    #1;
    ewg = do_rst ? 2'b00 : arb(wreq, wr_last);
    erg = do_rst ? 2'b00 : arb(rreq, rd_last);
    chk("wr_gnt", 64'({w1_gnt, w0_gnt}), 64'(ewg));
    chk("rd_gnt", 64'({r1_gnt, r0_gnt}), 64'(erg));
    // Reads granted this cycle see memory before any write granted this cycle.
    if (erg != 2'b00) begin
      id = erg[1];
      q.push_back('{id: id, data: ref_mem[raddr[id]], due: cyc + RD_LAT + 2});
      rd_last = id;
    end
    if (ewg != 2'b00) begin
      id = ewg[1];
      ref_mem[waddr[id]] = wdata[id];
      wr_last = id;
    end
    if (do_rst) begin
      wr_last = 1'b1;
      rd_last = 1'b1;
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
    end
`ifdef DPRAM_ARB_STATS_EN
    if (do_rst) begin
      m_wr = 0; m_rd = 0; m_stall = 0;
    end else begin
      m_wr += 32'(ewg != 2'b00);
      m_rd += 32'(erg != 2'b00);
      m_stall += 32'(((wreq & ~ewg) != 2'b00) || ((rreq & ~erg) != 2'b00));
    end
`endif
    @(posedge clk);
    #1;
    wreq = wreq & ~ewg;
    rreq = rreq & ~erg;
    wgot = ewg;
    rgot = erg;
`ifdef DPRAM_ARB_STATS_EN
    chk("stat_wr", 64'(stat_wr_cnt), 64'(m_wr));
    chk("stat_rd", 64'(stat_rd_cnt), 64'(m_rd));
    chk("stat_stall", 64'(stat_stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic issue_w(input int c, input int a, input logic [DW-1:0] d);
    if (!wreq[c]) begin
      wreq[c] = 1'b1; waddr[c] = AW'(a); wdata[c] = d;
    end
  endtask

  task automatic issue_r(input int c, input int a);
    if (!rreq[c]) begin
      rreq[c] = 1'b1; raddr[c] = AW'(a);
    end
  endtask

  // Monitor: pops the scoreboard on every return strobe and watches rdata/reset state.
  logic rst_at_edge;
  logic [DW-1:0] last_rd [2];
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst_at_edge) begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        chk("rst_rvalid", 64'({r1_rvalid, r0_rvalid}), 64'(0));
        chk("rst_wena_renb", 64'({ram_wena, ram_renb}), 64'(0));
        chk("rst_porta", 64'({ram_addra, ram_dina}), 64'(0));
        chk("rst_addrb", 64'(ram_addrb), 64'(0));
      end else begin
        chk("renb_run", 64'(ram_renb), 64'(1));
      end
      if (r0_rvalid || r1_rvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", 64'({r1_rvalid, r0_rvalid}), 64'(0));
        end else begin
          e = q.pop_front();
          chk("rvalid_client", 64'({r1_rvalid, r0_rvalid}), e.id ? 64'(2) : 64'(1));
          chk("rvalid_cycle", 64'(cyc), 64'(e.due));
          chk("rdata", 64'(e.id ? r1_rdata : r0_rdata), 64'(e.data));
          last_rd[e.id] = e.data;
        end
      end
      chk("r0_rdata_hold", 64'(r0_rdata), 64'(last_rd[0]));
      chk("r1_rdata_hold", 64'(r1_rdata), 64'(last_rd[1]));
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("rvalid_timeout", 64'(q[0].due), 64'(cyc));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int wc [2];
    int ia, ib, guard;
    bit r;
    rst = 1'b1; wreq = '0; rreq = '0; preload = 1'b1;
    wr_last = 1'b1; rd_last = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    for (int c = 0; c < 2; c++) begin
      waddr[c] = '0; wdata[c] = '0; raddr[c] = '0;
    end
    reinit_ref();
`ifdef DPRAM_ARB_STATS_EN
    m_wr = 0; m_rd = 0; m_stall = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    mon_en = 1'b1;
    step(1'b1); step(1'b1);

    // Single write then read of the same address by the other read client.
    issue_w(0, 5, 32'hDEADBEEF);
    step(1'b0); step(1'b0);
    issue_r(1, 5);
    step(1'b0);
    idle(RD_LAT + 4);

    // Write contention from reset: strict alternation starting with w0.
    step(1'b1); step(1'b1);
    wc[0] = 0; wc[1] = 0;
    repeat (8) begin
      issue_w(0, 1, $urandom);
      issue_w(1, 2, $urandom);
      step(1'b0);
      if (wgot != 2'b00) wc[wgot[1]]++;
    end
    chk("contention_w0_grants", 64'(wc[0]), 64'(4));
    chk("contention_w1_grants", 64'(wc[1]), 64'(4));
    wreq = '0;
    idle(2);

    // Read interleave over a freshly preloaded RAM.
    preload = 1'b1;
    step(1'b0);
    preload = 1'b0;
    reinit_ref();
    ia = 0; ib = 0; guard = 0;
    while ((ia < 8 || ib < 8 || rreq != 2'b00) && guard < 40) begin
      if (!rreq[0] && ia < 8) begin issue_r(0, ia); ia++; end
      if (!rreq[1] && ib < 8) begin issue_r(1, ib); ib++; end
      step(1'b0);
      guard++;
    end
    chk("stream_done", 64'({ia[7:0], ib[7:0]}), 64'(16'h0808));
    idle(RD_LAT + 4);

    // Same-cycle write and read of addr 9, then re-read.
    issue_w(1, 9, 32'h55);
    issue_r(0, 9);
    step(1'b0);
    issue_r(0, 9);
    step(1'b0);
    idle(RD_LAT + 4);

    // Reset with reads in flight; next conflicts go to client 0.
    step(1'b1);
    issue_r(0, 3); issue_r(1, 4);
    step(1'b0);
    issue_r(0, 6);
    step(1'b0);
    step(1'b1); step(1'b1);
    issue_w(0, 7, 32'hA5A5_0000); issue_w(1, 8, 32'h0000_5A5A);
    issue_r(1, 7);
    step(1'b0);
    idle(RD_LAT + 6);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(1, 0) == 1) issue_w(c, $urandom_range(DEPTH-1, 0), $urandom);
        if ($urandom_range(1, 0) == 1) issue_r(c, $urandom_range(DEPTH-1, 0));
      end
      r = ($urandom_range(499, 0) == 0);
      step(r);
    end
    wreq = '0; rreq = '0;
    idle(RD_LAT + 6);
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
